// File: rtl/piradip_right_shift_pipe.sv
// Pipelined logarithmic right shifter on a valid/ready stream.
// Each stage handles one shift bit, MSB first, and carries the remaining shift bits,
// a running sticky bit and tlast. Vacated bits are zero or sign fill depending on ARITH.
module piradip_right_shift_pipe #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHIFT_WIDTH = $clog2(DATA_WIDTH) + 1,
  parameter bit          ARITH       = 1'b0
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [SHIFT_WIDTH+DATA_WIDTH-1:0] s_tdata,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  input  logic                              s_tlast,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic                              m_tuser,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tlast
);

  // Remaining shift bits of every stage packed into one triangular vector:
  // stage k keeps SHIFT_WIDTH-1-k bits, the last stage keeps none.
  localparam int unsigned RemW = SHIFT_WIDTH * (SHIFT_WIDTH - 1) / 2;

  logic [SHIFT_WIDTH-1:0] vld_q;
  logic [SHIFT_WIDTH-1:0] sticky_q;
  logic [SHIFT_WIDTH-1:0] last_q;
  logic [DATA_WIDTH-1:0]  data_q [SHIFT_WIDTH];
  logic [RemW-1:0]        rem_q;
  logic [SHIFT_WIDTH:0]   rdy;

  assign rdy[SHIFT_WIDTH] = m_tready;

  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    localparam int unsigned InW = SHIFT_WIDTH - k;
    localparam int unsigned Amt = 2 ** (SHIFT_WIDTH - 1 - k);

    logic                  vld_in;
    logic                  sticky_in;
    logic                  last_in;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_sh;
    logic [InW-1:0]        sh_in;
    logic                  fill;
    logic                  lost;
    logic                  do_shift;

    if (k == 0) begin : g_src
      assign vld_in    = s_tvalid;
      assign d_in      = s_tdata[DATA_WIDTH-1:0];
      assign sh_in     = s_tdata[DATA_WIDTH +: SHIFT_WIDTH];
      assign sticky_in = 1'b0;
      assign last_in   = s_tlast;
    end else begin : g_src
      localparam int unsigned InOff = (k - 1) * (SHIFT_WIDTH - 1) - ((k - 1) * (k - 2)) / 2;
      assign vld_in    = vld_q[k-1];
      assign d_in      = data_q[k-1];
      assign sh_in     = rem_q[InOff +: InW];
      assign sticky_in = sticky_q[k-1];
      assign last_in   = last_q[k-1];
    end

    // The data MSB is preserved by every arithmetic stage, so it is the original sign.
    assign fill     = ARITH ? d_in[DATA_WIDTH-1] : 1'b0;
    assign do_shift = sh_in[InW-1];

    if (Amt >= DATA_WIDTH) begin : g_shift
      assign d_sh = {DATA_WIDTH{fill}};
      assign lost = |d_in;
    end else begin : g_shift
      assign d_sh = (d_in >> Amt) | ({DATA_WIDTH{fill}} << (DATA_WIDTH - Amt));
      assign lost = |d_in[Amt-1:0];
    end

    // A stage can take a new beat when empty or when its content moves on this edge.
    assign rdy[k] = ~vld_q[k] | rdy[k+1];

    // Stage registers: advance on rdy, load payload only for a valid upstream beat.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        vld_q[k]    <= 1'b0;
        data_q[k]   <= '0;
        sticky_q[k] <= 1'b0;
        last_q[k]   <= 1'b0;
      end else if (rdy[k]) begin
        vld_q[k] <= vld_in;
        if (vld_in) begin
          data_q[k]   <= do_shift ? d_sh : d_in;
          sticky_q[k] <= sticky_in | (do_shift & lost);
          last_q[k]   <= last_in;
        end
      end
    end

    if (k < SHIFT_WIDTH - 1) begin : g_rem
      localparam int unsigned OutW   = InW - 1;
      localparam int unsigned OutOff = k * (SHIFT_WIDTH - 1) - (k * (k - 1)) / 2;

      // Remaining shift bits travel with the beat, one bit narrower per stage.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          rem_q[OutOff +: OutW] <= '0;
        end else if (rdy[k] && vld_in) begin
          rem_q[OutOff +: OutW] <= sh_in[OutW-1:0];
        end
      end
    end
  end

  assign s_tready = rdy[0] & aresetn;
  assign m_tvalid = vld_q[SHIFT_WIDTH-1];
  assign m_tdata  = data_q[SHIFT_WIDTH-1];
  assign m_tuser  = sticky_q[SHIFT_WIDTH-1];
  assign m_tlast  = last_q[SHIFT_WIDTH-1];

endmodule

// File: tb/tb_piradip_right_shift_pipe.sv
// Bench for piradip_right_shift_pipe: a logical and an arithmetic instance share one input
// stream; outputs are scored against a plain-arithmetic shift model.
module tb_piradip_right_shift_pipe;
  localparam int DW = 32;
  localparam int SW = 6;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [SW+DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, m_tready;
  logic          s_tready0, s_tready1;
  logic [DW-1:0] m_tdata0, m_tdata1;
  logic          m_tuser0, m_tuser1, m_tvalid0, m_tvalid1, m_tlast0, m_tlast1;

  piradip_right_shift_pipe #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW), .ARITH(1'b0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready0), .s_tlast(s_tlast), .m_tdata(m_tdata0), .m_tuser(m_tuser0),
    .m_tvalid(m_tvalid0), .m_tready(m_tready), .m_tlast(m_tlast0)
  );

  piradip_right_shift_pipe #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW), .ARITH(1'b1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready1), .s_tlast(s_tlast), .m_tdata(m_tdata1), .m_tuser(m_tuser1),
    .m_tvalid(m_tvalid1), .m_tready(m_tready), .m_tlast(m_tlast1)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word shift in one step; sticky is the OR of the discarded low bits.
  function automatic logic [32:0] ref_shift(input logic [31:0] d, input int unsigned sh,
                                            input bit arith);
    logic [31:0]        r;
    logic signed [31:0] ds;
    logic [63:0]        mask;
    logic               st;
    if (sh >= 32) begin
      r  = (arith && d[31]) ? 32'hFFFF_FFFF : 32'h0;
      st = |d;
    end else begin
      ds = d;
      if (arith) r = ds >>> sh;
      else       r = d >> sh;
      mask = (64'd1 << sh) - 64'd1;
      st   = |({32'h0, d} & mask);
    end
    return {st, r};
  endfunction

  typedef struct {
    logic [31:0] d0, d1;
    logic        u0, u1, l;
  } exp_t;

  exp_t        sb[$];
  int          out_cyc[$];
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          acc = 1'b0;
  bit          rand_rdy = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] held_d0;
  logic        held_u0, held_l0;
  logic [31:0] last_d0, last_d1;
  logic        last_u0, last_u1, last_l0;

  // Monitor at the falling edge: values here are what the next rising edge samples.
  initial forever begin
    @(negedge aclk);
    cyc++;
    acc = s_tvalid && s_tready0;
    if (acc) begin
      exp_t        e;
      logic [32:0] r0, r1;
      check_eq("s_tready_arith", 32'(s_tready1), 32'd1);
      r0   = ref_shift(s_tdata[DW-1:0], 32'(s_tdata[SW+DW-1:DW]), 1'b0);
      r1   = ref_shift(s_tdata[DW-1:0], 32'(s_tdata[SW+DW-1:DW]), 1'b1);
      e.d0 = r0[31:0];
      e.u0 = r0[32];
      e.d1 = r1[31:0];
      e.u1 = r1[32];
      e.l  = s_tlast;
      sb.push_back(e);
      acc_cyc = cyc;
    end
    if (stall_prev) begin
      check_eq("hold_valid", 32'(m_tvalid0), 32'd1);
      check_eq("hold_data", m_tdata0, held_d0);
      check_eq("hold_user", 32'(m_tuser0), 32'(held_u0));
      check_eq("hold_last", 32'(m_tlast0), 32'(held_l0));
    end
    if (m_tvalid0 && m_tready) begin
      out_cyc.push_back(cyc);
      last_d0 = m_tdata0;
      last_d1 = m_tdata1;
      last_u0 = m_tuser0;
      last_u1 = m_tuser1;
      last_l0 = m_tlast0;
      if (sb.size() == 0) begin
        check_eq("unexpected_out", 32'(m_tvalid0), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("data_logic", m_tdata0, e.d0);
        check_eq("user_logic", 32'(m_tuser0), 32'(e.u0));
        check_eq("last_logic", 32'(m_tlast0), 32'(e.l));
        check_eq("valid_arith", 32'(m_tvalid1), 32'd1);
        check_eq("data_arith", m_tdata1, e.d1);
        check_eq("user_arith", 32'(m_tuser1), 32'(e.u1));
        check_eq("last_arith", 32'(m_tlast1), 32'(e.l));
      end
    end
    stall_prev = m_tvalid0 && !m_tready;
    held_d0    = m_tdata0;
    held_u0    = m_tuser0;
    held_l0    = m_tlast0;
  end

  task automatic step();
    @(posedge aclk);
    #1;
    if (rand_rdy) m_tready = 1'($urandom % 2);
  endtask

  task automatic send(input logic [31:0] d, input logic [5:0] sh, input logic l, input bit gaps);
    bit done = 1'b0;
    if (gaps) begin
      while (($urandom % 2) == 0) begin
        s_tvalid = 1'b0;
        step();
      end
    end
    s_tvalid = 1'b1;
    s_tdata  = {sh, d};
    s_tlast  = l;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    check_eq("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    #1;
    check_eq("rst_m_tvalid", 32'(m_tvalid0), 32'd0);
    check_eq("rst_m_tdata", m_tdata0, 32'd0);
    check_eq("rst_m_tuser", 32'(m_tuser0), 32'd0);
    check_eq("rst_m_tlast", 32'(m_tlast0), 32'd0);
    check_eq("rst_s_tready", 32'(s_tready0), 32'd0);
    #11 aresetn = 1'b1;
    #1 check_eq("post_rst_s_tready", 32'(s_tready0), 32'd1);
    step();

    // Logical shift by 4, sticky from bit 0, latency.
    out_cyc.delete();
    send(32'h8000_0001, 6'd4, 1'b0, 1'b0);
    idle();
    drain();
    check_eq("t1_data", last_d0, 32'h0800_0000);
    check_eq("t1_user", 32'(last_u0), 32'd1);
    check_eq("t1_count", 32'(out_cyc.size()), 32'd1);
    if (out_cyc.size() > 0) check_eq("t1_latency", 32'(out_cyc[0] - acc_cyc), 32'd6);

    // Sign fill and oversize shifts.
    send(32'h8000_0000, 6'd31, 1'b0, 1'b0);
    idle();
    drain();
    check_eq("t2_arith31_data", last_d1, 32'hFFFF_FFFF);
    check_eq("t2_arith31_user", 32'(last_u1), 32'd0);
    send(32'h8000_0000, 6'd40, 1'b0, 1'b0);
    idle();
    drain();
    check_eq("t2_arith40_data", last_d1, 32'hFFFF_FFFF);
    check_eq("t2_logic40_data", last_d0, 32'h0);
    check_eq("t2_logic40_user", 32'(last_u0), 32'd1);

    // Zero shift passes through, tlast carried.
    send(32'h1234_5678, 6'd0, 1'b1, 1'b0);
    idle();
    drain();
    check_eq("t3_data", last_d0, 32'h1234_5678);
    check_eq("t3_data_arith", last_d1, 32'h1234_5678);
    check_eq("t3_user", 32'(last_u0), 32'd0);
    check_eq("t3_last", 32'(last_l0), 32'd1);

    // 64 back-to-back beats at full rate.
    out_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 64; i++)
      send($urandom, 6'($urandom_range(0, 63)), 1'($urandom % 2), 1'b0);
    c1 = cyc;
    idle();
    drain();
    check_eq("t4_accept_cycles", 32'(c1 - c0), 32'd64);
    check_eq("t4_out_count", 32'(out_cyc.size()), 32'd64);
    if (out_cyc.size() == 64) check_eq("t4_out_span", 32'(out_cyc[63] - out_cyc[0]), 32'd63);

    // 20 beats with random source gaps and sink stalls; tlast on the final beat.
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++)
      send($urandom, 6'($urandom_range(0, 63)), 1'(i == 19), 1'b1);
    idle();
    drain();
    check_eq("t5_last", 32'(last_l0), 32'd1);
    rand_rdy = 1'b0;
    m_tready = 1'b1;
    step();

    // Asynchronous reset with beats in flight.
    for (int i = 0; i < 4; i++) send($urandom, 6'($urandom_range(0, 63)), 1'b0, 1'b0);
    idle();
    #2 aresetn = 1'b0;
    #1;
    check_eq("t6_m_tvalid", 32'(m_tvalid0), 32'd0);
    check_eq("t6_m_tvalid_arith", 32'(m_tvalid1), 32'd0);
    check_eq("t6_m_tdata", m_tdata1, 32'd0);
    check_eq("t6_s_tready", 32'(s_tready0), 32'd0);
    sb.delete();
    @(posedge aclk);
    @(posedge aclk);
    #3 aresetn = 1'b1;
    out_cyc.delete();
    #1 check_eq("t6_s_tready_rel", 32'(s_tready0), 32'd1);
    step();
    send(32'hDEAD_BEEF, 6'd8, 1'b0, 1'b0);
    idle();
    drain();
    for (int i = 0; i < 12; i++) step();
    check_eq("t6_out_count", 32'(out_cyc.size()), 32'd1);
    check_eq("t6_data", last_d0, 32'h00DE_ADBE);
    check_eq("t6_user", 32'(last_u0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
